// File: rtl/seg_data_drive.sv
// seg_data_drive
// Segment-data stage for an 8-digit multiplexed seven-segment display.
// Display content arrives over a valid/ready port into a pending buffer.
// It is copied into the active buffer only at a frame boundary, so a scan
// never shows a torn frame. The stage also provides per-digit blink,
// per-digit decimal points and optional leading-zero blanking.
//
// Optional feature macro: SEG_LZB_EN (leading-zero blanking, computed at commit).
//
// Parameters:
//   BLINK_HALF  clk cycles per blink half-period (1..65535)
// Ports:
//   clk          scan clock, shared with the digit-select stage
//   rst_n        asynchronous active-low reset
//   sel_in[7:0]  one-cold digit select; bit i low enables digit i
//   upd_valid    update payload valid
//   upd_ready    pending slot free
//   upd_data     eight hex codes; digit i is upd_data[4i+3:4i]
//   upd_dp       per-digit decimal point, 1 = lit
//   blink_mask   per-digit blink enable, sampled every cycle
//   seg_out      {dp,g,f,e,d,c,b,a}, active-high, registered
//   frame_start  one-cycle pulse after sel_in == 8'h7F is sampled
//   sel_err      sticky flag: sel_in was seen not one-cold
module seg_data_drive #(
    parameter int BLINK_HALF = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sel_in,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_data,
    input  logic [7:0]  upd_dp,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  seg_out,
    output logic        frame_start,
    output logic        sel_err
);

    localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

    // Hex code to {g,f,e,d,c,b,a} glyph.
    function automatic logic [6:0] hex_glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            4'hF:    g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

`ifdef SEG_LZB_EN
    // Blank digit i (i >= 1) when it and every digit to its left are zero.
    function automatic logic [7:0] lzb_mask(input logic [31:0] data);
        logic [7:0] m;
        logic       zero_run;
        m        = 8'h00;
        zero_run = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_run = zero_run && (data[4*i +: 4] == 4'h0);
            m[i]     = zero_run;
        end
        return m;
    endfunction
`endif

    logic [31:0] pend_data_r;
    logic [7:0]  pend_dp_r;
    logic        pend_valid_r;
    logic [31:0] act_data_r;
    logic [7:0]  act_dp_r;
    logic [15:0] blink_cnt_r;
    logic        blink_phase_r;

    logic [3:0]  zero_cnt_s;
    logic [2:0]  sel_idx_s;
    logic        sel_ok_s;
    logic        frame_sel_s;
    logic        commit_s;
    logic        xfer_s;
    logic [31:0] view_data_s;
    logic [7:0]  view_dp_s;
    logic [7:0]  view_blank_s;
    logic [3:0]  code_s;
    logic [7:0]  seg_next_s;

`ifdef SEG_LZB_EN
    logic [7:0]  act_blank_r;
`endif

    assign upd_ready = ~pend_valid_r;

    // Locate the enabled digit and count how many digits are enabled.
    always_comb begin
        zero_cnt_s = 4'd0;
        sel_idx_s  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            zero_cnt_s = zero_cnt_s + {3'd0, ~sel_in[i]};
            if (!sel_in[i]) begin
                sel_idx_s = 3'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
        sel_ok_s = (zero_cnt_s == 4'd1);
    end

    assign frame_sel_s = (sel_in == 8'h7F);
    assign commit_s    = frame_sel_s && pend_valid_r;
    assign xfer_s      = upd_valid && ~pend_valid_r;

    // The segment mux reads the post-commit view so digit 7 of a committing
    // frame already shows the new content.
    always_comb begin
        if (commit_s) begin
            view_data_s = pend_data_r;
            view_dp_s   = pend_dp_r;
        end else begin
            view_data_s = act_data_r;
            view_dp_s   = act_dp_r;
        end
`ifdef SEG_LZB_EN
        if (commit_s) begin
            view_blank_s = lzb_mask(pend_data_r);
        end else begin
            view_blank_s = act_blank_r;
        end
`else
        view_blank_s = 8'h00;
`endif
    end

    assign code_s = view_data_s[{sel_idx_s, 2'b00} +: 4];

    // Compose the next segment pattern: glyph, decimal point, blanking, blink.
    always_comb begin
        seg_next_s = 8'h00;
        if (!sel_ok_s) begin
            seg_next_s = 8'h00;
        end else if (blink_phase_r && blink_mask[sel_idx_s]) begin
            seg_next_s = 8'h00;
        end else if (view_blank_s[sel_idx_s]) begin
            seg_next_s = {view_dp_s[sel_idx_s], 7'h00};
        end else begin
            seg_next_s = {view_dp_s[sel_idx_s], hex_glyph(code_s)};
        end
    end

    // Pending slot: capture on transfer, release on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_data_r  <= 32'h0000_0000;
            pend_dp_r    <= 8'h00;
        end else if (commit_s) begin
            pend_valid_r <= 1'b0;
        end else if (xfer_s) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= upd_data;
            pend_dp_r    <= upd_dp;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    // Active buffer: loaded from pending only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data_r <= 32'h0000_0000;
            act_dp_r   <= 8'h00;
        end else if (commit_s) begin
            act_data_r <= pend_data_r;
            act_dp_r   <= pend_dp_r;
        end else begin
            act_data_r <= act_data_r;
        end
    end

`ifdef SEG_LZB_EN
    // Blank mask follows the active data; all-zero content leaves only digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_blank_r <= 8'hFE;
        end else if (commit_s) begin
            act_blank_r <= lzb_mask(pend_data_r);
        end else begin
            act_blank_r <= act_blank_r;
        end
    end
`endif

    // Free-running blink timebase; phase 0 is the visible half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r   <= 16'd0;
            blink_phase_r <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r   <= 16'd0;
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + 16'd1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out     <= 8'h00;
            frame_start <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            seg_out     <= seg_next_s;
            frame_start <= frame_sel_s;
            sel_err     <= sel_err | ~sel_ok_s;
        end
    end

endmodule

// File: tb/tb_seg_data_drive.sv
// Testbench for seg_data_drive: a reference model derived from the display
// rules checks every output each cycle; literal expectations pin key points.
module tb_seg_data_drive;

    localparam int BH = 4;
    localparam logic [7:0] GLYPH [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sel_in;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_data;
    logic [7:0]  upd_dp;
    logic [7:0]  blink_mask;
    logic [7:0]  seg_out;
    logic        frame_start;
    logic        sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    seg_data_drive #(.BLINK_HALF(BH)) dut (
        .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_data(upd_data), .upd_dp(upd_dp),
        .blink_mask(blink_mask), .seg_out(seg_out), .frame_start(frame_start),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic        m_pend_v;
    logic [31:0] m_pend_data, m_act_data;
    logic [7:0]  m_pend_dp, m_act_dp;
    logic        m_err;
    int          m_edges;
    logic [7:0]  e_seg;
    logic        e_frame;

    // Model update on every clock edge, then compare the DUT shortly after.
    always @(posedge clk) begin
        int    idx;
        bit    invalid;
        logic [3:0] code;
        if (!rst_n) begin
            m_pend_v = 1'b0; m_pend_data = 32'h0; m_pend_dp = 8'h0;
            m_act_data = 32'h0; m_act_dp = 8'h0; m_err = 1'b0; m_edges = 0;
            e_seg = 8'h00; e_frame = 1'b0;
        end else begin
            invalid = ($countones(~sel_in) != 1);
            if (sel_in == 8'h7F && m_pend_v) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_pend_v = 1'b0;
            end else if (upd_valid && !m_pend_v) begin
                m_pend_data = upd_data; m_pend_dp = upd_dp; m_pend_v = 1'b1;
            end
            if (invalid) begin
                e_seg = 8'h00;
                m_err = 1'b1;
            end else begin
                idx = 0;
                for (int i = 0; i < 8; i++) if (!sel_in[i]) idx = i;
                code  = 4'((m_act_data >> (4 * idx)) & 32'hF);
                e_seg = GLYPH[code];
`ifdef SEG_LZB_EN
                if (idx != 0 && (m_act_data >> (4 * idx)) == 32'h0) e_seg = 8'h00;
`endif
                if (m_act_dp[idx]) e_seg = e_seg | 8'h80;
                if (((m_edges / BH) % 2) == 1 && blink_mask[idx]) e_seg = 8'h00;
            end
            e_frame = (sel_in == 8'h7F);
            m_edges++;
        end
        #1;
        check("seg_out", {24'h0, seg_out}, {24'h0, e_seg});
        check("frame_start", {31'h0, frame_start}, {31'h0, e_frame});
        check("sel_err", {31'h0, sel_err}, {31'h0, m_err});
        check("upd_ready", {31'h0, upd_ready}, {31'h0, ~m_pend_v});
    end

    task automatic tick(input logic [7:0] s);
        @(negedge clk);
        sel_in = s;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] slot(input int k);
        logic [7:0] one;
        one = 8'h80;
        return ~(one >> k);
    endfunction

    task automatic frame_ticks(input int from, input int to);
        for (int k = from; k <= to; k++) tick(slot(k));
    endtask

    logic [7:0] zero7;
    logic [7:0] blink_rec [16];

    initial begin
`ifdef SEG_LZB_EN
        zero7 = 8'h00;
`else
        zero7 = 8'h3F;
`endif
        rst_n = 1'b0; sel_in = 8'h7F; upd_valid = 1'b0; upd_data = 32'h0;
        upd_dp = 8'h0; blink_mask = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("reset seg", {24'h0, seg_out}, 32'h00);
        check("reset ready", {31'h0, upd_ready}, 32'h1);
        rst_n = 1'b1;

        // Frame A: all-zero content after reset
        tick(slot(0));
        check("A slot7", {24'h0, seg_out}, {24'h0, zero7});
        check("A frame_start", {31'h0, frame_start}, 32'h1);
        frame_ticks(1, 7);
        check("A slot0", {24'h0, seg_out}, 32'h3F);
        check("A ready", {31'h0, upd_ready}, 32'h1);

        // Frame B: update accepted mid-frame, old content continues
        frame_ticks(0, 2);
        upd_valid = 1'b1; upd_data = 32'h0000_1234; upd_dp = 8'h04;
        tick(slot(3));
        upd_valid = 1'b0;
        check("B ready low", {31'h0, upd_ready}, 32'h0);
        frame_ticks(4, 7);
        check("B old slot0", {24'h0, seg_out}, 32'h3F);

        // Frame C: new content from digit 7 onwards
        tick(slot(0));
        check("C slot7", {24'h0, seg_out}, {24'h0, zero7});
        check("C ready back", {31'h0, upd_ready}, 32'h1);
        frame_ticks(1, 4);
        check("C slot3", {24'h0, seg_out}, 32'h06);
        tick(slot(5));
        check("C slot2 dp", {24'h0, seg_out}, 32'hDB);
        tick(slot(6));
        check("C slot1", {24'h0, seg_out}, 32'h4F);
        tick(slot(7));
        check("C slot0", {24'h0, seg_out}, 32'h66);

        // Frame D: one payload captured, second held while pending
        tick(slot(0));
        upd_valid = 1'b1; upd_data = 32'h8765_4321; upd_dp = 8'h80;
        tick(slot(1));
        check("D ready low", {31'h0, upd_ready}, 32'h0);
        upd_data = 32'hFEDC_BA98; upd_dp = 8'h01;
        frame_ticks(2, 7);
        check("D no tear", {24'h0, seg_out}, 32'h66);
        check("D still pending", {31'h0, upd_ready}, 32'h0);

        // Frame E: commit 87654321, held payload transfers right after
        tick(slot(0));
        check("E slot7", {24'h0, seg_out}, 32'hFF);
        tick(slot(1));
        upd_valid = 1'b0;
        check("E second capture", {31'h0, upd_ready}, 32'h0);
        frame_ticks(2, 7);
        check("E slot0", {24'h0, seg_out}, 32'h06);

        // Frame F: FEDCBA98 shown
        tick(slot(0));
        check("F slot7", {24'h0, seg_out}, 32'h71);
        frame_ticks(1, 7);
        check("F slot0", {24'h0, seg_out}, 32'hFF);

        // Frame G: transfer coincides with frame start, commits one frame later
        upd_valid = 1'b1; upd_data = 32'h0000_0005; upd_dp = 8'h00;
        tick(slot(0));
        upd_valid = 1'b0;
        check("G not committed", {24'h0, seg_out}, 32'h71);
        frame_ticks(1, 7);

        // Frame H
        tick(slot(0));
        check("H slot7", {24'h0, seg_out}, {24'h0, zero7});
        frame_ticks(1, 7);
        check("H slot0", {24'h0, seg_out}, 32'h6D);

        // Blink on digit 0 with a fixed select
        blink_mask = 8'h01;
        for (int i = 0; i < 16; i++) begin
            tick(8'hFE);
            blink_rec[i] = seg_out;
        end
        for (int i = 0; i < 12; i++) begin
            check("blink alternates", {31'h0, (blink_rec[i] == 8'h00) != (blink_rec[i+4] == 8'h00)}, 32'h1);
            check("blink value", {31'h0, blink_rec[i] == 8'h00 || blink_rec[i] == 8'h6D}, 32'h1);
        end
        blink_mask = 8'h00;

        // Invalid selects
        tick(8'hFC);
        check("inv seg", {24'h0, seg_out}, 32'h00);
        check("inv err", {31'h0, sel_err}, 32'h1);
        tick(8'hFF);
        check("allones seg", {24'h0, seg_out}, 32'h00);
        tick(8'hFE);
        check("recover seg", {24'h0, seg_out}, 32'h6D);
        check("err sticky", {31'h0, sel_err}, 32'h1);

        // Asynchronous reset mid-frame with a payload pending
        tick(slot(0));
        upd_valid = 1'b1; upd_data = 32'h1111_1111; upd_dp = 8'hFF;
        tick(slot(1));
        upd_valid = 1'b0;
        tick(slot(2));
        #1;
        rst_n = 1'b0;
        #1;
        check("async seg", {24'h0, seg_out}, 32'h00);
        check("async ready", {31'h0, upd_ready}, 32'h1);
        check("async frame", {31'h0, frame_start}, 32'h0);
        check("async err", {31'h0, sel_err}, 32'h0);
        tick(slot(3));
        tick(slot(4));
        rst_n = 1'b1;
        frame_ticks(0, 7);
        check("post-reset slot0", {24'h0, seg_out}, 32'h3F);
        tick(slot(0));
        check("pending discarded", {24'h0, seg_out}, {24'h0, zero7});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
